// File: rtl/wb_stage_ex.sv
// -----------------------------------------------------------------------------
// wb_stage_ex
// MEM/WB pipeline register and writeback unit.
// The stage register captures the memory-stage result each cycle. It can hold
// (stall) or be emptied (flush). Load data is aligned and extended after the
// register. GPR writes to $0 are suppressed, and so are writes from illegal or
// misaligned loads. The unit also counts retired instructions.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   stall_i, flush_i   hold / invalidate the stage (flush has priority)
//   mem_*              memory-stage instruction fields captured by the register
//   we_o, wAddr_o,     GPR write port
//   wData_o
//   hi_we_o, lo_we_o,  HI/LO write port
//   hi_o, lo_o
//   align_err_o        registered load is misaligned or of an illegal type
//   retired_o          count of instructions that have left the stage (wraps)
// -----------------------------------------------------------------------------
module wb_stage_ex #(
   parameter  int DATA_W = 32,
   parameter  int REG_AW = 5,
   parameter  int CNT_W  = 32,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              mem_valid_i,
   input  logic              mem_regWr_i,
   input  logic [REG_AW-1:0] mem_regAddr_i,
   input  logic              mem_memToReg_i,
   input  logic [DATA_W-1:0] mem_aluData_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [2:0]        mem_loadType_i,
   input  logic [OFF_W-1:0]  mem_byteOff_i,
   input  logic [1:0]        mem_hiloWr_i,
   input  logic [DATA_W-1:0] mem_hi_i,
   input  logic [DATA_W-1:0] mem_lo_i,
   output logic              we_o,
   output logic [REG_AW-1:0] wAddr_o,
   output logic [DATA_W-1:0] wData_o,
   output logic              hi_we_o,
   output logic              lo_we_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              align_err_o,
   output logic [CNT_W-1:0]  retired_o
);

   typedef enum logic [2:0] {
      LT_LB  = 3'd0,
      LT_LBU = 3'd1,
      LT_LH  = 3'd2,
      LT_LHU = 3'd3,
      LT_LW  = 3'd4,
      LT_LWU = 3'd5,
      LT_LD  = 3'd6,
      LT_RSV = 3'd7
   } load_t;

   // Stage register
   logic              r_valid;
   logic              r_regWr;
   logic [REG_AW-1:0] r_regAddr;
   logic              r_memToReg;
   logic [DATA_W-1:0] r_aluData;
   logic [DATA_W-1:0] r_rdata;
   load_t             r_loadType;
   logic [OFF_W-1:0]  r_byteOff;
   logic [1:0]        r_hiloWr;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [CNT_W-1:0]  r_retired;

   // Load alignment
   logic [DATA_W-1:0] w_shifted;
   logic [DATA_W-1:0] w_mask;
   logic              w_sign;
   logic              w_bad;
   logic [DATA_W-1:0] w_load;
   logic              w_alignErr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_regWr    <= 1'b0;
         r_regAddr  <= '0;
         r_memToReg <= 1'b0;
         r_aluData  <= '0;
         r_rdata    <= '0;
         r_loadType <= LT_LB;
         r_byteOff  <= '0;
         r_hiloWr   <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else if (flush_i) begin
         // Only valid matters for an empty stage; the payload is left as is.
         r_valid <= 1'b0;
      end else if (!stall_i) begin
         r_valid    <= mem_valid_i;
         r_regWr    <= mem_regWr_i;
         r_regAddr  <= mem_regAddr_i;
         r_memToReg <= mem_memToReg_i;
         r_aluData  <= mem_aluData_i;
         r_rdata    <= mem_rdata_i;
         r_loadType <= load_t'(mem_loadType_i);
         r_byteOff  <= mem_byteOff_i;
         r_hiloWr   <= mem_hiloWr_i;
         r_hi       <= mem_hi_i;
         r_lo       <= mem_lo_i;
      end
   end

   // An instruction leaves the stage when it is not held, or when it is flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired <= '0;
      end else if (r_valid && (!stall_i || flush_i)) begin
         r_retired <= r_retired + 1'b1;
      end
   end

   // Shift the addressed lane down to bit 0. Then keep the lane width with a
   // mask and fill the bits above it with the sign bit or with zeros. Using a
   // mask avoids a zero-width replication for word loads when DATA_W is 32.
   assign w_shifted = r_rdata >> {r_byteOff, 3'b000};

   always_comb begin
      w_mask = '1;
      w_sign = 1'b0;
      w_bad  = 1'b0;
      case (r_loadType)
         LT_LB: begin
            w_mask = DATA_W'(8'hFF);
            w_sign = w_shifted[7];
         end
         LT_LBU: begin
            w_mask = DATA_W'(8'hFF);
         end
         LT_LH: begin
            w_mask = DATA_W'(16'hFFFF);
            w_sign = w_shifted[15];
            w_bad  = r_byteOff[0];
         end
         LT_LHU: begin
            w_mask = DATA_W'(16'hFFFF);
            w_bad  = r_byteOff[0];
         end
         LT_LW: begin
            w_mask = DATA_W'(32'hFFFF_FFFF);
            w_sign = w_shifted[31];
            w_bad  = (r_byteOff[1:0] != 2'b00);
         end
         LT_LWU: begin
            w_mask = DATA_W'(32'hFFFF_FFFF);
            w_bad  = (r_byteOff[1:0] != 2'b00);
         end
         LT_LD: begin
            w_bad = (DATA_W != 64) || (r_byteOff != '0);
         end
         default: begin
            w_bad = 1'b1;
         end
      endcase
   end

   assign w_load     = (w_shifted & w_mask) | (w_sign ? ~w_mask : '0);
   assign w_alignErr = r_valid & r_memToReg & w_bad;

   assign align_err_o = w_alignErr;
   assign wAddr_o     = r_regAddr;
   assign wData_o     = r_memToReg ? w_load : r_aluData;
   assign we_o        = r_valid & r_regWr & (r_regAddr != '0) & ~w_alignErr;
   assign hi_we_o     = r_valid & r_hiloWr[1];
   assign lo_we_o     = r_valid & r_hiloWr[0];
   assign hi_o        = r_hi;
   assign lo_o        = r_lo;
   assign retired_o   = r_retired;

endmodule

// File: tb/tb_wb_stage_ex.sv
module tb_wb_stage_ex;

   logic        clk;
   logic        rst;
   logic        stall_i, flush_i;
   logic        valid, regWr, m2r;
   logic [4:0]  regAddr;
   logic [31:0] alu, rdata, hi, lo;
   logic [2:0]  lt;
   logic [1:0]  off, hilo;

   logic        we_a, hi_we_a, lo_we_a, err_a;
   logic [4:0]  wAddr_a;
   logic [31:0] wData_a, hi_a, lo_a, ret_a;
   logic        we_b, hi_we_b, lo_we_b, err_b;
   logic [4:0]  wAddr_b;
   logic [31:0] wData_b, hi_b, lo_b;
   logic [3:0]  ret_b;

   wb_stage_ex #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .mem_valid_i(valid), .mem_regWr_i(regWr), .mem_regAddr_i(regAddr),
      .mem_memToReg_i(m2r), .mem_aluData_i(alu), .mem_rdata_i(rdata),
      .mem_loadType_i(lt), .mem_byteOff_i(off), .mem_hiloWr_i(hilo),
      .mem_hi_i(hi), .mem_lo_i(lo),
      .we_o(we_a), .wAddr_o(wAddr_a), .wData_o(wData_a), .hi_we_o(hi_we_a),
      .lo_we_o(lo_we_a), .hi_o(hi_a), .lo_o(lo_a), .align_err_o(err_a),
      .retired_o(ret_a)
   );

   wb_stage_ex #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .mem_valid_i(valid), .mem_regWr_i(regWr), .mem_regAddr_i(regAddr),
      .mem_memToReg_i(m2r), .mem_aluData_i(alu), .mem_rdata_i(rdata),
      .mem_loadType_i(lt), .mem_byteOff_i(off), .mem_hiloWr_i(hilo),
      .mem_hi_i(hi), .mem_lo_i(lo),
      .we_o(we_b), .wAddr_o(wAddr_b), .wData_o(wData_b), .hi_we_o(hi_we_b),
      .lo_we_o(lo_we_b), .hi_o(hi_b), .lo_o(lo_b), .align_err_o(err_b),
      .retired_o(ret_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: the instruction currently in the stage, plus a count of
   // the instructions that have left it.
   logic            m_valid, m_regWr, m_m2r;
   logic [4:0]      m_addr;
   logic [31:0]     m_alu, m_rdata, m_hi, m_lo;
   logic [2:0]      m_lt;
   logic [1:0]      m_off, m_hilo;
   longint unsigned m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bad_load(input logic [2:0] t, input logic [1:0] o);
      int unsigned oi = int'(o);
      case (t)
         3'd2, 3'd3: return (oi % 2) != 0;
         3'd4, 3'd5: return (oi % 4) != 0;
         3'd6:       return 1'b1;   // a doubleword load cannot occur on a 32-bit datapath
         3'd7:       return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] t, input logic [1:0] o,
                                            input logic [31:0] word);
      logic [31:0] sh = word >> (8 * int'(o));
      byte         sb = byte'(sh[7:0]);
      shortint     sw = shortint'(sh[15:0]);
      case (t)
         3'd0:       return 32'(int'(sb));
         3'd1:       return 32'(sh[7:0]);
         3'd2:       return 32'(int'(sw));
         3'd3:       return 32'(sh[15:0]);
         3'd4, 3'd5: return sh;
         default:    return word;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_regWr = 0; m_m2r = 0; m_addr = '0; m_alu = '0; m_rdata = '0;
      m_hi = '0; m_lo = '0; m_lt = '0; m_off = '0; m_hilo = '0; m_cnt = 0;
   endtask

   task automatic check_all();
      logic        e_err, e_we;
      logic [31:0] e_data;
      e_err  = m_valid && m_m2r && bad_load(m_lt, m_off);
      e_we   = m_valid && m_regWr && (m_addr != 0) && !e_err;
      e_data = m_m2r ? load_val(m_lt, m_off, m_rdata) : m_alu;
      chk("we", we_a, e_we);
      chk("we4", we_b, e_we);
      chk("align_err", err_a, e_err);
      chk("align_err4", err_b, e_err);
      chk("hi_we", hi_we_a, m_valid && m_hilo[1]);
      chk("lo_we", lo_we_a, m_valid && m_hilo[0]);
      chk("hi_we4", hi_we_b, m_valid && m_hilo[1]);
      chk("lo_we4", lo_we_b, m_valid && m_hilo[0]);
      chk("retired", ret_a, m_cnt % 64'h1_0000_0000);
      chk("retired4", ret_b, m_cnt % 16);
      if (m_valid) begin
         chk("wAddr", wAddr_a, m_addr);
         chk("wAddr4", wAddr_b, m_addr);
         chk("hi", hi_a, m_hi);
         chk("lo", lo_a, m_lo);
         chk("hi4", hi_b, m_hi);
         chk("lo4", lo_b, m_lo);
         if (!e_err) begin
            chk("wData", wData_a, e_data);
            chk("wData4", wData_b, e_data);
         end
      end
   endtask

   // Advance one clock edge and update the model the way the stage should
   // behave, then sample the outputs 1 time unit after the edge.
   task automatic step();
      logic f, s, retire;
      f      = flush_i;
      s      = stall_i;
      retire = m_valid && (!s || f);
      @(posedge clk);
      if (retire) m_cnt++;
      if (f) begin
         m_valid = 1'b0;
      end else if (!s) begin
         m_valid = valid; m_regWr = regWr; m_addr = regAddr; m_m2r = m2r;
         m_alu = alu; m_rdata = rdata; m_lt = lt; m_off = off; m_hilo = hilo;
         m_hi = hi; m_lo = lo;
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      chk("rst_we", we_a, 0);
      chk("rst_wAddr", wAddr_a, 0);
      chk("rst_wData", wData_a, 0);
      chk("rst_hi_we", hi_we_a, 0);
      chk("rst_lo_we", lo_we_a, 0);
      chk("rst_hi", hi_a, 0);
      chk("rst_lo", lo_a, 0);
      chk("rst_align_err", err_a, 0);
      chk("rst_retired", ret_a, 0);
      chk("rst_retired4", ret_b, 0);
      chk("rst_we4", we_b, 0);
      model_reset();
      #4;
      rst = 1'b0;
   endtask

   task automatic idle_inputs();
      stall_i = 0; flush_i = 0; valid = 0; regWr = 0; regAddr = '0; m2r = 0;
      alu = '0; rdata = '0; lt = '0; off = '0; hilo = '0; hi = '0; lo = '0;
   endtask

   task automatic rand_inputs();
      valid   = ($urandom_range(0, 9) < 8);
      regWr   = 1'($urandom);
      regAddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      m2r     = 1'($urandom);
      alu     = $urandom;
      rdata   = $urandom;
      lt      = 3'($urandom);
      off     = 2'($urandom);
      hilo    = 2'($urandom);
      hi      = $urandom;
      lo      = $urandom;
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
   endtask

   typedef struct {
      logic [2:0]  lt;
      logic [1:0]  off;
      logic [4:0]  addr;
      logic [1:0]  hilo;
      logic        exp_we;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[16];

   initial begin
      longint unsigned c0;

      vecs = '{
         '{3'd0, 2'd3, 5'd7,  2'd0, 1'b1, 1'b0, 32'hFFFF_FF80},
         '{3'd1, 2'd1, 5'd8,  2'd0, 1'b1, 1'b0, 32'h0000_00F2},
         '{3'd2, 2'd2, 5'd9,  2'd0, 1'b1, 1'b0, 32'hFFFF_8081},
         '{3'd3, 2'd0, 5'd10, 2'd0, 1'b1, 1'b0, 32'h0000_F27F},
         '{3'd0, 2'd0, 5'd11, 2'd1, 1'b1, 1'b0, 32'h0000_007F},
         '{3'd1, 2'd3, 5'd12, 2'd2, 1'b1, 1'b0, 32'h0000_0080},
         '{3'd2, 2'd0, 5'd13, 2'd0, 1'b1, 1'b0, 32'hFFFF_F27F},
         '{3'd3, 2'd2, 5'd14, 2'd0, 1'b1, 1'b0, 32'h0000_8081},
         '{3'd2, 2'd1, 5'd15, 2'd0, 1'b0, 1'b1, 32'h0},
         '{3'd4, 2'd2, 5'd16, 2'd3, 1'b0, 1'b1, 32'h0},
         '{3'd4, 2'd0, 5'd17, 2'd0, 1'b1, 1'b0, 32'h8081_F27F},
         '{3'd5, 2'd0, 5'd18, 2'd0, 1'b1, 1'b0, 32'h8081_F27F},
         '{3'd6, 2'd0, 5'd19, 2'd0, 1'b0, 1'b1, 32'h0},
         '{3'd7, 2'd0, 5'd20, 2'd0, 1'b0, 1'b1, 32'h0},
         '{3'd0, 2'd2, 5'd0,  2'd3, 1'b0, 1'b0, 32'hFFFF_FF81},
         '{3'd3, 2'd3, 5'd21, 2'd0, 1'b0, 1'b1, 32'h0}
      };

      idle_inputs();
      do_reset();

      // Single ALU op: written the next cycle, retired one edge later.
      valid = 1; regWr = 1; regAddr = 5'd5; m2r = 0; alu = 32'h1234_5678;
      step();
      chk("alu_we", we_a, 1);
      chk("alu_wAddr", wAddr_a, 5);
      chk("alu_wData", wData_a, 32'h1234_5678);
      chk("alu_ret0", ret_a, 0);
      idle_inputs();
      step();
      chk("alu_ret1", ret_a, 1);

      // Load alignment and extension table on a fixed memory word.
      foreach (vecs[i]) begin
         valid = 1; regWr = 1; m2r = 1; rdata = 32'h8081_F27F; alu = $urandom;
         lt = vecs[i].lt; off = vecs[i].off; regAddr = vecs[i].addr;
         hilo = vecs[i].hilo; hi = $urandom; lo = $urandom;
         step();
         chk($sformatf("vec%0d_we", i), we_a, vecs[i].exp_we);
         chk($sformatf("vec%0d_err", i), err_a, vecs[i].exp_err);
         if (!vecs[i].exp_err) chk($sformatf("vec%0d_data", i), wData_a, vecs[i].exp_data);
      end

      // Hold for three cycles while the inputs change, then flush during a stall.
      valid = 1; regWr = 1; regAddr = 5'd9; m2r = 0; alu = 32'hCAFE_0001;
      hilo = 2'b10; hi = 32'h1111_2222; lo = 32'h3333_4444;
      step();
      c0 = m_cnt;
      stall_i = 1;
      for (int k = 0; k < 3; k++) begin
         rand_inputs();
         stall_i = 1; flush_i = 0;
         step();
         chk("stall_we", we_a, 1);
         chk("stall_wAddr", wAddr_a, 9);
         chk("stall_wData", wData_a, 32'hCAFE_0001);
         chk("stall_hi", hi_a, 32'h1111_2222);
         chk("stall_ret", ret_a, c0);
      end
      flush_i = 1;
      step();
      chk("flush_we", we_a, 0);
      chk("flush_ret", ret_a, c0 + 1);
      idle_inputs();
      step();
      chk("flush_ret_after", ret_a, c0 + 1);

      // 4-bit counter wraps after 17 retirements.
      do_reset();
      for (int k = 0; k < 17; k++) begin
         valid = 1; regWr = 1; regAddr = 5'(k + 1); m2r = 0; alu = $urandom;
         step();
      end
      idle_inputs();
      step();
      chk("wrap4", ret_b, 1);
      chk("wrap32", ret_a, 17);

      // Random traffic, with an asynchronous reset dropped in between edges.
      for (int k = 0; k < 400; k++) begin
         rand_inputs();
         step();
         if (k == 200) begin
            #2;
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage_ex.md
# wb_stage_ex

Parametrised MEM/WB pipeline register and writeback unit for the MIPS core. It captures the memory-stage result each cycle and supports stall and flush. Load data is aligned and extended after the register, and illegal targets are suppressed. It drives the register-file write port, the HI/LO write port and a retired-instruction counter.

## Interface
- DATA_W, 32: datapath width; legal values 32 or 64.
- REG_AW, 5: register-file address width.
- CNT_W, 32: retired-instruction counter width.
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived; do not override).

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hold the stage contents
- flush_i  in  1  invalidate the stage on the next edge
- mem_valid_i  in  1  memory stage holds a real instruction
- mem_regWr_i  in  1  instruction writes a GPR
- mem_regAddr_i  in  REG_AW  destination GPR
- mem_memToReg_i  in  1  1 = result from load data, 0 = from ALU
- mem_aluData_i  in  DATA_W  ALU result
- mem_rdata_i  in  DATA_W  raw memory read word
- mem_loadType_i  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW (32-bit, sign-extended), 5 LWU, 6 LD (full DATA_W), 7 reserved
- mem_byteOff_i  in  OFF_W  byte address of the load within the word
- mem_hiloWr_i  in  2  bit1 writes HI, bit0 writes LO
- mem_hi_i, mem_lo_i  in  DATA_W  HI/LO results
- we_o  out  1  GPR write enable
- wAddr_o  out  REG_AW  GPR write address
- wData_o  out  DATA_W  GPR write data
- hi_we_o, lo_we_o  out  1  HI/LO write enables
- hi_o, lo_o  out  DATA_W  HI/LO write data
- align_err_o  out  1  registered load is misaligned or of an illegal type
- retired_o  out  CNT_W  count of instructions that have left the stage

## Operation
- Stage register holds: valid, regWr, regAddr, memToReg, aluData, rdata, loadType, byteOff, hiloWr, hi, lo.
- Each rising edge updates the register with this priority:
  - flush_i = 1: valid is cleared; other fields are don't-care.
  - else stall_i = 1: all fields hold.
  - else: all fields load from the mem_* inputs.
- Load alignment is combinational from the registered fields:
  - Byte select: rdata[8*off +: 8]. Half select: rdata[8*off +: 16]. Word select: rdata[8*off +: 32].
  - Signed types (LB, LH, LW) sign-extend to DATA_W; unsigned types zero-extend.
- Misalignment rules:
  - LH/LHU require off[0] = 0.
  - LW/LWU require off[1:0] = 0; for DATA_W = 64, off[2] may be 0 or 1.
  - LD requires off = 0 and DATA_W = 64; with DATA_W = 32, type 6 is illegal.
  - Type 7 is always illegal.
- align_err_o = valid & memToReg & (misaligned | illegal type).
- wData_o = memToReg ? aligned load data : aluData.
- wAddr_o = registered regAddr.
- we_o = valid & regWr & (regAddr != 0) & ~align_err_o. Writes to $0 are never issued.
- hi_we_o = valid & hiloWr[1]; lo_we_o = valid & hiloWr[0]; hi_o and lo_o are the registered hi and lo.
- HI/LO writes are independent of align_err_o.
- retired_o increments by 1 on an edge where registered valid = 1 and (stall_i = 0 or flush_i = 1), i.e. when the instruction leaves the stage.
- retired_o wraps from 2^CNT_W−1 to 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Outputs are combinational from the stage register only; there is no input-to-output combinational path.
- While stalled, we_o stays asserted with the same address and data; repeated writes are idempotent by design.
- Flush and stall in the same cycle: flush wins; the stage becomes empty.
- Reset (asynchronous, mid-operation included) clears every register and the counter immediately. While rst = 1, all outputs are 0, including retired_o and align_err_o.
- First capture occurs on the first rising edge after rst deasserts.

## Test plan
- Reset then one ALU op (valid=1, regWr=1, addr=5, aluData=0x1234_5678) → the next cycle we_o=1, wAddr_o=5, wData_o=0x1234_5678, retired_o increments 0→1 one edge later.
- LB/LBU/LH/LHU on rdata=0x8081_F27F at each legal offset → LB off=3 gives 0xFFFF_FF80, LBU off=1 gives 0x0000_00F2, LH off=2 gives 0xFFFF_8081, LHU off=0 gives 0x0000_F27F.
- LH off=1 and LW off=2 → align_err_o=1, we_o=0; LW off=0 → align_err_o=0, we_o=1.
- Write to addr 0 with regWr=1 → we_o=0; a concurrent hiloWr=2'b11 still gives hi_we_o=lo_we_o=1 with the registered values.
- Stall for 3 cycles mid-stream → outputs hold and retired_o is frozen; flush asserted together with stall → we_o=0 on the next cycle and retired_o increments once.
- CNT_W=4: retire 17 instructions → retired_o=1 (wrap). Assert rst asynchronously between edges → all outputs 0 immediately.
